// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side blocks.
package fifo_pkg;

  localparam int FWFT_DEPTH = 3;
  localparam int FWFT_CNT_W = 2;

  typedef logic [FWFT_CNT_W-1:0] fwft_idx_t;

  // Buffer indices wrap at FWFT_DEPTH rather than at the natural 2-bit boundary.
  function automatic fwft_idx_t fwft_next_idx(input fwft_idx_t idx);
    return (idx == fwft_idx_t'(FWFT_DEPTH - 1)) ? '0 : idx + fwft_idx_t'(1);
  endfunction

endpackage

// File: rtl/rptr_fwft_out_if.sv
// Read-side handshake between the pointer/memory stage, the FWFT front end and its consumer.
interface rptr_fwft_out_if #(
  parameter int DSIZE = 8
);

  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;

  modport master (
    input  rempty,
    input  rdata,
    output rinc,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output rempty,
    output rdata,
    input  rinc,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/rptr_fwft_out.sv
// First-word-fall-through read front end: prefetches FIFO words into a 3-entry output buffer.
// Optional accepted-word counter (port pop_cnt) enabled by macro RPTR_FWFT_POPCNT_EN.
module rptr_fwft_out
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic            rclk,
  input  logic            rrst,
  rptr_fwft_out_if.master bus
`ifdef RPTR_FWFT_POPCNT_EN
  ,
  output logic [15:0]     pop_cnt
`endif
);

  localparam logic [FWFT_CNT_W:0] DEPTH_LIM = FWFT_DEPTH[FWFT_CNT_W:0];

  logic [DSIZE-1:0]    buf_mem [FWFT_DEPTH];
  fwft_idx_t           count;
  fwft_idx_t           wr_idx;
  fwft_idx_t           rd_idx;
  logic                inflight;
  logic                capture;
  logic                pop;
  logic [FWFT_CNT_W:0] occupancy;

  // The outstanding read is counted as occupied, so a returning word always finds a free slot.
  assign occupancy   = {1'b0, count} + {{FWFT_CNT_W{1'b0}}, inflight};
  assign bus.rinc    = ~rrst & ~bus.rempty & (occupancy < DEPTH_LIM);

  assign capture     = inflight;
  assign pop         = bus.m_valid & bus.m_ready;
  assign bus.m_valid = (count != '0);
  assign bus.m_data  = buf_mem[rd_idx];

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      count    <= '0;
      inflight <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      for (int i = 0; i < FWFT_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      inflight <= bus.rinc;
      if (capture) begin
        buf_mem[wr_idx] <= bus.rdata;
        wr_idx          <= fwft_next_idx(wr_idx);
      end
      if (pop) begin
        rd_idx <= fwft_next_idx(rd_idx);
      end
      case ({capture, pop})
        2'b10:   count <= count + fwft_idx_t'(1);
        2'b01:   count <= count - fwft_idx_t'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef RPTR_FWFT_POPCNT_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      pop_cnt <= '0;
    end else if (pop) begin
      pop_cnt <= pop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rptr_fwft_out.sv
// Bench for rptr_fwft_out: a queue-based upstream FIFO feeds the DUT, delivered words are scoreboarded.
// Define RPTR_FWFT_POPCNT_EN to also check pop_cnt.
`timescale 1ns/1ps
module tb_rptr_fwft_out;

  localparam int DSIZE = 8;

  logic rclk = 1'b0;
  logic rrst;

  rptr_fwft_out_if #(.DSIZE(DSIZE)) bus ();

`ifdef RPTR_FWFT_POPCNT_EN
  logic [15:0] pop_cnt;
`endif

  rptr_fwft_out #(.DSIZE(DSIZE)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .bus     (bus)
`ifdef RPTR_FWFT_POPCNT_EN
    ,
    .pop_cnt (pop_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  src_q[$];
  logic [7:0]  exp_q[$];
  bit          hold_empty;
  int          outstanding;
  int          max_out;
  logic        obs_rinc;
  logic        obs_valid;
  logic        obs_pop;
  logic [7:0]  obs_data;
  logic [15:0] exp_popcnt;

  task automatic reset_model();
    src_q.delete();
    exp_q.delete();
    hold_empty  = 1'b0;
    outstanding = 0;
    max_out     = 0;
    exp_popcnt  = '0;
  endtask

  // One clock: sample outputs mid-cycle, then play the upstream FIFO just after the edge.
  task automatic cycle(input logic ready);
    bus.m_ready = ready;
    @(negedge rclk);
    obs_rinc  = bus.rinc;
    obs_valid = bus.m_valid;
    obs_data  = bus.m_data;
    obs_pop   = bus.m_valid & ready;
    @(posedge rclk);
    #1;
    if (obs_pop) begin
      outstanding--;
      exp_popcnt++;
    end
    if (obs_rinc) begin
      outstanding++;
      if (src_q.size() > 0) begin
        bus.rdata = src_q.pop_front();
        exp_q.push_back(bus.rdata);
      end else begin
        bus.rdata = 8'hEE;
      end
    end else begin
      bus.rdata = 8'($urandom);
    end
    if (outstanding > max_out) max_out = outstanding;
    bus.rempty = hold_empty || (src_q.size() == 0);
  endtask

  task automatic test_reset();
    logic [7:0] exp_w;
    reset_model();
    rrst = 1'b1;
    src_q.push_back(8'h11);
    bus.rempty  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge rclk);
    checks++;
    if (bus.rinc !== 1'b0) begin errors++; $display("[TB] FAIL reset_rinc: got %b, required 0", bus.rinc); end
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", bus.m_valid); end
    checks++;
    if (bus.m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h, required 00", bus.m_data); end
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    cycle(1'b1);
    checks++;
    if (obs_rinc !== 1'b1) begin errors++; $display("[TB] FAIL release_rinc: got %b, required 1", obs_rinc); end
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1);
      if (obs_pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL reset_word: got %h, required no word", obs_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs_data !== exp_w) begin errors++; $display("[TB] FAIL reset_word: got %h, required %h", obs_data, exp_w); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL reset_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_first_word();
    src_q.push_back(8'hA5);
    bus.rempty = 1'b0;
    cycle(1'b1);
    checks++;
    if (obs_rinc !== 1'b1) begin errors++; $display("[TB] FAIL fw_rinc: got %b, required 1", obs_rinc); end
    cycle(1'b1);
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL fw_early_valid: got %b, required 0", obs_valid); end
    cycle(1'b1);
    checks++;
    if (obs_valid !== 1'b1) begin errors++; $display("[TB] FAIL fw_valid: got %b, required 1", obs_valid); end
    checks++;
    if (obs_data !== 8'hA5) begin errors++; $display("[TB] FAIL fw_data: got %h, required a5", obs_data); end
    if (obs_pop && exp_q.size() > 0) void'(exp_q.pop_front());
    cycle(1'b1);
    checks++;
    if (obs_valid !== 1'b0) begin errors++; $display("[TB] FAIL fw_after_pop: got %b, required 0", obs_valid); end
  endtask

  task automatic test_streaming();
    int got = 0;
    int last_c = 0;
    int gap_err = 0;
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    bus.rempty = 1'b0;
    max_out = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      cycle(1'b1);
      if (obs_pop) begin
        checks++;
        if (obs_data !== 8'(got)) begin errors++; $display("[TB] FAIL stream_word: got %h, required %h", obs_data, 8'(got)); end
        if (got > 0 && c != last_c + 1) gap_err++;
        last_c = c;
        got++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (got != 16) begin errors++; $display("[TB] FAIL stream_count: got %0d, required 16", got); end
    checks++;
    if (gap_err != 0) begin errors++; $display("[TB] FAIL stream_rate: got %0d bubbles, required 0", gap_err); end
    checks++;
    if (max_out > 3) begin errors++; $display("[TB] FAIL stream_overflow: got %0d, required <=3", max_out); end
  endtask

  task automatic test_backpressure();
    logic [7:0] words[$];
    logic [7:0] held = '0;
    bit         have = 0;
    int         rinc_cnt = 0;
    int         stable_err = 0;
    int         got = 0;
    for (int i = 0; i < 12; i++) begin
      words.push_back(8'($urandom));
      src_q.push_back(words[i]);
    end
    bus.rempty = 1'b0;
    max_out = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0);
      if (obs_rinc) rinc_cnt++;
      if (obs_valid) begin
        if (!have) begin held = obs_data; have = 1; end
        else if (obs_data !== held) stable_err++;
      end
    end
    checks++;
    if (rinc_cnt != 3) begin errors++; $display("[TB] FAIL bp_rinc_pulses: got %0d, required 3", rinc_cnt); end
    checks++;
    if (stable_err != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes, required 0", stable_err); end
    checks++;
    if (held !== words[0]) begin errors++; $display("[TB] FAIL bp_head: got %h, required %h", held, words[0]); end
    checks++;
    if (outstanding != 3) begin errors++; $display("[TB] FAIL bp_fill: got %0d, required 3", outstanding); end
    for (int c = 0; c < 40 && got < 12; c++) begin
      cycle(1'b1);
      if (obs_pop) begin
        checks++;
        if (obs_data !== words[got]) begin errors++; $display("[TB] FAIL bp_word: got %h, required %h", obs_data, words[got]); end
        got++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (got != 12) begin errors++; $display("[TB] FAIL bp_count: got %0d, required 12", got); end
    checks++;
    if (max_out > 3) begin errors++; $display("[TB] FAIL bp_overflow: got %0d, required <=3", max_out); end
  endtask

  task automatic test_empty_midstream();
    logic [7:0] words[$];
    int         got = 0;
    int         rinc_held = 0;
    int         got_in_hold;
    for (int i = 0; i < 6; i++) begin
      words.push_back(8'($urandom));
      src_q.push_back(words[i]);
    end
    bus.rempty = 1'b0;
    for (int c = 0; c < 47 && got < 6; c++) begin
      if (c == 2) begin
        hold_empty = 1'b1;
        bus.rempty = 1'b1;
      end
      if (c == 7) begin
        checks++;
        got_in_hold = got;
        if (got_in_hold != 2) begin errors++; $display("[TB] FAIL empty_inflight: got %0d words, required 2", got_in_hold); end
        hold_empty = 1'b0;
        bus.rempty = (src_q.size() == 0);
      end
      cycle(1'b1);
      if (c >= 2 && c < 7 && obs_rinc) rinc_held++;
      if (obs_pop) begin
        checks++;
        if (got >= 6) begin
          errors++; $display("[TB] FAIL empty_word: got %h, required no word", obs_data);
        end else if (obs_data !== words[got]) begin
          errors++; $display("[TB] FAIL empty_word: got %h, required %h", obs_data, words[got]);
        end
        got++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    checks++;
    if (rinc_held != 0) begin errors++; $display("[TB] FAIL empty_rinc: got %0d pulses, required 0", rinc_held); end
    checks++;
    if (got != 6) begin errors++; $display("[TB] FAIL empty_count: got %0d, required 6", got); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp_w;
    int         got = 0;
    for (int i = 0; i < 10; i++) src_q.push_back(8'($urandom));
    bus.rempty = 1'b0;
    repeat (3) cycle(1'b0);
    checks++;
    if (outstanding != 3) begin errors++; $display("[TB] FAIL mr_prefill: got %0d, required 3", outstanding); end
    rrst = 1'b1;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mr_valid: got %b, required 0", bus.m_valid); end
    checks++;
    if (bus.rinc !== 1'b0) begin errors++; $display("[TB] FAIL mr_rinc: got %b, required 0", bus.rinc); end
    checks++;
    if (bus.m_data !== 8'h00) begin errors++; $display("[TB] FAIL mr_data: got %h, required 00", bus.m_data); end
`ifdef RPTR_FWFT_POPCNT_EN
    checks++;
    if (pop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mr_popcnt: got %0d, required 0", pop_cnt); end
`endif
    reset_model();
    bus.rempty = 1'b1;
    bus.rdata  = 8'($urandom);
    repeat (2) @(posedge rclk);
    #1;
    rrst = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
    bus.rempty = 1'b0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      cycle(1'b1);
      if (obs_pop) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL mr_word: got %h, required no word", obs_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs_data !== exp_w) begin errors++; $display("[TB] FAIL mr_word: got %h, required %h", obs_data, exp_w); end
        end
`ifdef RPTR_FWFT_POPCNT_EN
        checks++;
        if (pop_cnt !== 16'(got)) begin errors++; $display("[TB] FAIL mr_popcnt_inc: got %0d, required %0d", pop_cnt, got); end
`endif
      end
    end
    checks++;
    if (got != 5) begin errors++; $display("[TB] FAIL mr_count: got %0d, required 5", got); end
  endtask

  task automatic test_random();
    logic [7:0] exp_w;
    logic [7:0] prev_data;
    bit         prev_stall = 0;
    max_out = 0;
    for (int c = 0; c < 500; c++) begin
      if (c < 400) begin
        if ($urandom_range(0, 2) == 0 && src_q.size() < 8) src_q.push_back(8'($urandom));
        if ($urandom_range(0, 7) == 0) hold_empty = ~hold_empty;
      end else begin
        hold_empty = 1'b0;
      end
      bus.rempty = hold_empty || (src_q.size() == 0);
      cycle((c >= 400) ? 1'b1 : 1'($urandom_range(0, 1)));
      if (prev_stall) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== prev_data) begin
          errors++; $display("[TB] FAIL rnd_hold: got valid=%b data=%h, required valid=1 data=%h", obs_valid, obs_data, prev_data);
        end
      end
      prev_stall = obs_valid & ~obs_pop;
      prev_data  = obs_data;
      checks++;
      if (outstanding > 3) begin errors++; $display("[TB] FAIL rnd_overflow: got %0d, required <=3", outstanding); end
      if (obs_pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rnd_word: got %h, required no word", obs_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (obs_data !== exp_w) begin errors++; $display("[TB] FAIL rnd_word: got %h, required %h", obs_data, exp_w); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || src_q.size() != 0) begin
      errors++; $display("[TB] FAIL rnd_drain: got %0d/%0d pending, required 0/0", exp_q.size(), src_q.size());
    end
`ifdef RPTR_FWFT_POPCNT_EN
    checks++;
    if (pop_cnt !== exp_popcnt) begin errors++; $display("[TB] FAIL rnd_popcnt: got %0d, required %0d", pop_cnt, exp_popcnt); end
`endif
  endtask

  initial begin
    rrst        = 1'b0;
    bus.rempty  = 1'b1;
    bus.rdata   = '0;
    bus.m_ready = 1'b0;
    #1;
    rrst = 1'b1;
    $display("[TB] start");
    test_reset();
    test_first_word();
    test_streaming();
    test_backpressure();
    test_empty_midstream();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rptr_fwft_out.md
RPTR_FWFT_OUT -- requirements
Module: rptr_fwft_out

Interface
REQ-001 SHALL have parameter DSIZE, default 8, width of one FIFO data word.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rrst  input  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have port rempty  input  1  registered empty flag from the read-pointer/empty stage.
REQ-005 SHALL have port rdata  input  DSIZE  memory read data, valid the cycle after the rising edge at which rinc was sampled high.
REQ-006 SHALL have port rinc  output  1  read request to the read-pointer stage.
REQ-007 SHALL have port m_valid  output  1  output word available.
REQ-008 SHALL have port m_data  output  DSIZE  output word; head of the internal buffer.
REQ-009 SHALL have port m_ready  input  1  consumer accepts the word when m_valid and m_ready are both high.

Function
REQ-010 SHALL implement a first-word-fall-through read front end with a 3-entry output buffer (count 0..3) and a 1-bit inflight flag.
REQ-011 SHALL drive rinc = ~rempty & ((count + inflight) < 3), with no combinational path from m_ready to rinc.
REQ-012 SHALL set inflight on the next edge to (rinc), i.e. one read outstanding per issued rinc cycle.
REQ-013 SHALL write rdata into the buffer tail on each edge where inflight is high; rdata SHALL be ignored otherwise.
REQ-014 SHALL pop the head on each edge where m_valid & m_ready.
REQ-015 SHALL handle simultaneous capture and pop: count unchanged, order preserved.
REQ-016 SHALL drive m_valid = (count != 0) and m_data from a register (head entry), never directly from rdata.
REQ-017 SHALL give first-word latency of 2 edges: rempty low in cycle N -> rinc high in N -> captured at edge ending N+1 -> m_valid high in N+2.
REQ-018 SHALL sustain one word per cycle when rempty stays low and m_ready stays high.
REQ-019 SHALL never overflow: count + inflight never exceeds 3; the bench SHALL assert this.
REQ-020 SHALL keep m_data stable while m_valid & ~m_ready.
REQ-021 SHALL tolerate rempty rising while inflight is high; the inflight word is still captured.
REQ-022 SHALL keep buffer indices wrap-around modulo 3 (2-bit read and write indices, 3 wraps to 0).

Reset
REQ-023 SHALL, while rrst is high, hold count=0, inflight=0, indices=0, m_valid=0, m_data=0, rinc=0.
REQ-024 SHALL, on rrst asserted mid-operation, discard buffered and inflight words immediately; the upstream pointer stage is reset together with this block.
REQ-025 SHALL issue the first rinc no earlier than the first edge after rrst deasserts.

Configuration
REQ-026 SHALL support macro RPTR_FWFT_POPCNT_EN: when defined, adds output port pop_cnt (16 bits) counting accepted words (m_valid & m_ready), wrapping at 65535->0, reset to 0.
REQ-027 SHALL, without RPTR_FWFT_POPCNT_EN, have no pop_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-028 SHALL take localparams FWFT_DEPTH=3 and FWFT_CNT_W=2 from the shared package fifo_pkg.
REQ-029 SHALL be a single module with no sub-module; the 3-entry buffer is inline registers.

Verification
REQ-030 Reset: rrst=1 with rempty=0 -> rinc=0, m_valid=0, m_data=0; release -> rinc=1 next cycle.
REQ-031 First word: rempty falls, rdata=8'hA5 one cycle after rinc -> m_valid=1, m_data=8'hA5 exactly 2 cycles after rempty fell.
REQ-032 Streaming: 16 words 0x00..0x0F, rempty=0, m_ready=1 -> 16 words in order, one per cycle after the first.
REQ-033 Backpressure: m_ready=0 for 10 cycles, rempty=0 -> at most 3 rinc pulses, m_data stable, count=3; m_ready=1 -> words drain in order with no loss.
REQ-034 Empty mid-stream: rempty rises while inflight=1 -> inflight word captured, rinc=0 until rempty falls, no duplicate or missing words.
REQ-035 Mid-operation reset: rrst pulsed with count=2, inflight=1 -> m_valid=0 same cycle; with RPTR_FWFT_POPCNT_EN, pop_cnt=0 and increments by 1 per accepted word afterwards.
